// File: rtl/imem_block_responder.sv
// imem_block_responder
// Responder side of the instruction-cache block-fetch protocol. Serves
// 16-byte blocks out of a 1024-byte store after a programmable number of
// clock edges, and offers a byte-wide load port for filling the store
// while the responder is idle.

module imem_block_responder #(
  parameter int unsigned LATENCY = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         read,
  input  logic [5:0]   address,
  output logic [127:0] readdata,
  output logic         busywait,
  input  logic         load_en,
  input  logic [9:0]   load_addr,
  input  logic [7:0]   load_data,
  output logic         load_err,
  output logic [15:0]  fetch_count
);

  // Final value of the latency counter; the block is latched on the edge
  // where the counter already holds this value.
  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [7:0]     cnt_r;
  logic [5:0]     addr_r;
  logic [127:0]   readdata_r;
  logic [15:0]    fetch_count_r;
  logic           load_err_r;
  logic [7:0]     mem_r [0:1023];

  logic           capture_s;
  logic           finish_s;
  logic           load_ok_s;
  logic           load_rej_s;
  logic           busywait_s;
  logic [127:0]   block_s;

  // Next-state decode, request capture / completion strobes and busywait.
  always_comb begin
    state_next_s = state_r;
    busywait_s   = 1'b0;
    capture_s    = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        busywait_s = read;
        if (read) begin
          capture_s    = 1'b1;
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        busywait_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          finish_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        // Request still asserted after the handshake is a new request:
        // capture it on the edge that leaves DONE so there is no bubble.
        busywait_s = 1'b0;
        if (read) begin
          capture_s    = 1'b1;
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        busywait_s   = read;
        state_next_s = IDLE;
      end
    endcase
  end

  // Loads are only safe while nothing is being captured or served.
  always_comb begin
    load_ok_s  = 1'b0;
    load_rej_s = 1'b0;
    if (load_en) begin
      if ((state_r == IDLE) && !read) begin
        load_ok_s = 1'b1;
      end else begin
        load_rej_s = 1'b1;
      end
    end else begin
      load_ok_s  = 1'b0;
      load_rej_s = 1'b0;
    end
  end

  // Gather the 16 bytes of the captured block, byte k into bits [8k+7:8k].
  always_comb begin
    block_s = 128'h0;
    for (int k = 0; k < 16; k++) begin
      block_s[8*k +: 8] = mem_r[{addr_r, 4'(k)}];
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latency counter: cleared on capture, advanced each BUSY edge until done.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r <= 8'd0;
    end else if (capture_s) begin
      cnt_r <= 8'd0;
    end else if ((state_r == BUSY) && !finish_s) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Block address is frozen at capture; later address changes are ignored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_r <= 6'd0;
    end else if (capture_s) begin
      addr_r <= address;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Block data register, updated only when a fetch completes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      readdata_r <= 128'h0;
    end else if (finish_s) begin
      readdata_r <= block_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  // Completed-fetch counter, saturating at all ones.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_count_r <= 16'd0;
    end else if (finish_s && (fetch_count_r != 16'hFFFF)) begin
      fetch_count_r <= fetch_count_r + 16'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  // Rejected-load flag, high for the single cycle after the rejected edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      load_err_r <= 1'b0;
    end else begin
      load_err_r <= load_rej_s;
    end
  end

  // Instruction store; deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (load_ok_s) begin
      mem_r[load_addr] <= load_data;
    end
  end

  assign readdata    = readdata_r;
  assign busywait    = busywait_s;
  assign load_err    = load_err_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_imem_block_responder.sv
// Directed bench for imem_block_responder: one LATENCY=5 instance and one
// LATENCY=1 instance sharing clock, reset and the load port.

module tb_imem_block_responder;

  logic         CLK;
  logic         RESET;
  logic         load_en;
  logic [9:0]   load_addr;
  logic [7:0]   load_data;

  logic         read;
  logic [5:0]   address;
  logic [127:0] readdata;
  logic         busywait;
  logic         load_err;
  logic [15:0]  fetch_count;

  logic         read1;
  logic [5:0]   address1;
  logic [127:0] readdata1;
  logic         busywait1;
  logic         load_err1;
  logic [15:0]  fetch_count1;

  int n_cmp;
  int n_err;

  localparam logic [127:0] BLK1     = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] BLK63    = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
  localparam logic [127:0] BLK63_5A = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F15A;
  localparam logic [127:0] BLK1_AA  = 128'h0F0E0D0C0B0A090807060504030201AA;

  imem_block_responder #(.LATENCY(5)) dut (
    .CLK(CLK), .RESET(RESET), .read(read), .address(address),
    .readdata(readdata), .busywait(busywait), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_err(load_err),
    .fetch_count(fetch_count)
  );

  imem_block_responder #(.LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .read(read1), .address(address1),
    .readdata(readdata1), .busywait(busywait1), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_err(load_err1),
    .fetch_count(fetch_count1)
  );

  initial CLK = 1'b0;
  always #4 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    check("load_ok_err", {127'd0, load_err}, 128'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    RESET = 1'b0; read = 1'b0; address = 6'd0; read1 = 1'b0; address1 = 6'd0;
    load_en = 1'b0; load_addr = 10'd0; load_data = 8'd0;

    // Reset pulse, 4 ns wide
    #1 RESET = 1'b1;
    #2;
    check("rst_readdata", readdata, 128'd0);
    check("rst_busywait", {127'd0, busywait}, 128'd0);
    check("rst_fcount", {112'd0, fetch_count}, 128'd0);
    check("rst_loaderr", {127'd0, load_err}, 128'd0);
    #2 RESET = 1'b0;
    tick();
    check("idle_busywait", {127'd0, busywait}, 128'd0);

    // Fill block 1 with 00..0F and block 63 with F0..FF
    for (int i = 0; i < 16; i++) begin
      load_byte(10'h010 + 10'(i), 8'(i));
      load_byte(10'h3F0 + 10'(i), 8'hF0 + 8'(i));
    end
    load_en = 1'b0;

    // Single fetch of block 1
    read = 1'b1; address = 6'd1;
    #1 check("idle_bw_follows_read", {127'd0, busywait}, 128'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("single_bw_high", {127'd0, busywait}, 128'd1);
      if (i == 4) check("single_data_not_yet", readdata, 128'd0);
      tick();
    end
    check("single_data", readdata, BLK1);
    check("single_bw_low", {127'd0, busywait}, 128'd0);
    check("single_fcount", {112'd0, fetch_count}, 128'd1);
    read = 1'b0;
    tick();
    check("single_hold", readdata, BLK1);
    check("single_idle_bw", {127'd0, busywait}, 128'd0);

    // Back-to-back: block 1 then block 63 with read held high
    read = 1'b1; address = 6'd1;
    tick();
    address = 6'd63;
    repeat (5) tick();
    check("b2b_first_data", readdata, BLK1);
    check("b2b_first_bw", {127'd0, busywait}, 128'd0);
    check("b2b_fcount1", {112'd0, fetch_count}, 128'd2);
    tick();
    check("b2b_recapture_bw", {127'd0, busywait}, 128'd1);
    repeat (4) tick();
    check("b2b_before_done", readdata, BLK1);
    tick();
    check("b2b_second_data", readdata, BLK63);
    check("b2b_fcount2", {112'd0, fetch_count}, 128'd3);
    read = 1'b0;
    tick();

    // Load collision while BUSY
    read = 1'b1; address = 6'd1;
    tick();
    load_en = 1'b1; load_addr = 10'h010; load_data = 8'hAA;
    tick();
    load_en = 1'b0;
    check("coll_err_pulse", {127'd0, load_err}, 128'd1);
    tick();
    check("coll_err_clear", {127'd0, load_err}, 128'd0);
    repeat (3) tick();
    check("coll_data", readdata, BLK1);
    check("coll_fcount", {112'd0, fetch_count}, 128'd4);
    read = 1'b0;
    tick();

    // Accepted load followed immediately by a read of the same block
    load_byte(10'h3F0, 8'h5A);
    load_en = 1'b0;
    read = 1'b1; address = 6'd63;
    tick();
    tick();
    tick();
    // two cycles after capture: drop read and move address
    read = 1'b0; address = 6'd1;
    #1 check("dist_bw_busy", {127'd0, busywait}, 128'd1);
    repeat (3) tick();
    check("dist_data", readdata, BLK63_5A);
    check("dist_fcount", {112'd0, fetch_count}, 128'd5);
    check("dist_bw_low", {127'd0, busywait}, 128'd0);
    tick();
    check("dist_hold", readdata, BLK63_5A);

    // Reset in the middle of a fetch
    read = 1'b1; address = 6'd1;
    tick();
    read = 1'b0;
    tick();
    check("mid_bw_busy", {127'd0, busywait}, 128'd1);
    RESET = 1'b1;
    #1;
    check("mid_rst_bw", {127'd0, busywait}, 128'd0);
    check("mid_rst_data", readdata, 128'd0);
    check("mid_rst_fcount", {112'd0, fetch_count}, 128'd0);
    tick();
    RESET = 1'b0;
    #1;
    // store survives reset
    read = 1'b1; address = 6'd1;
    tick();
    repeat (5) tick();
    check("post_rst_data", readdata, BLK1);
    check("post_rst_fcount", {112'd0, fetch_count}, 128'd1);
    read = 1'b0;
    tick();

    // LATENCY=1 instance (it accepted the 0xAA load since it was idle)
    read1 = 1'b1; address1 = 6'd1;
    tick();
    check("l1_bw_busy", {127'd0, busywait1}, 128'd1);
    check("l1_data_not_yet", readdata1, 128'd0);
    tick();
    check("l1_data", readdata1, BLK1_AA);
    check("l1_bw_low", {127'd0, busywait1}, 128'd0);
    check("l1_fcount", {112'd0, fetch_count1}, 128'd1);
    read1 = 1'b0;
    tick();
    read1 = 1'b1; address1 = 6'd63;
    #1 check("l1_idle_bw", {127'd0, busywait1}, 128'd1);
    tick();
    tick();
    check("l1_second_data", readdata1, BLK63_5A);
    check("l1_fcount2", {112'd0, fetch_count1}, 128'd2);
    read1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
